raw2rgb_debayer: RTL and testbench



---
 rtl/raw2rgb_debayer_pkg.sv | 26 ++
 rtl/raw2rgb_debayer_if.sv | 28 ++
 rtl/raw2rgb_debayer_line_ram.sv | 23 ++
 rtl/raw2rgb_debayer.sv | 131 +++++++++++++
 tb/tb_raw2rgb_debayer.sv | 282 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/raw2rgb_debayer_pkg.sv
// raw2rgb_debayer shared definitions
// Bayer line parity, RGB field layout and packing helper
package raw2rgb_pkg;

    localparam logic BAYER_EVEN = 1'b0;
    localparam logic BAYER_ODD  = 1'b1;

    localparam int RGB_W = 24;
    localparam int R_LSB = 16;
    localparam int G_LSB = 8;
    localparam int B_LSB = 0;

    function automatic logic [RGB_W-1:0] pack_rgb(
        input logic [7:0] r,
        input logic [7:0] g,
        input logic [7:0] b
    );
        logic [RGB_W-1:0] p;
        p = '0;
        p[R_LSB +: 8] = r;
        p[G_LSB +: 8] = g;
        p[B_LSB +: 8] = b;
        return p;
    endfunction

endpackage

// File: rtl/raw2rgb_debayer_if.sv
// raw2rgb_debayer stream bundle
// RAW beats and frame flags in, RGB stream and re-timed flags out
interface raw2rgb_debayer_if
    import raw2rgb_pkg::*;
#(
    parameter int PIX_W = 10
);
    logic               in_frame;
    logic               in_line;
    logic               pix_in_valid;
    logic [2*PIX_W-1:0] pix_in;
    logic               rgb_enable;
    logic [RGB_W-1:0]   rgb_pix;
    logic               rgb_reading;
    logic               csi_out_line;
    logic               csi_out_frame;
    logic               line_ovf;

    modport master (
        output in_frame, in_line, pix_in_valid, pix_in, rgb_enable,
        input  rgb_pix, rgb_reading, csi_out_line, csi_out_frame, line_ovf
    );

    modport slave (
        input  in_frame, in_line, pix_in_valid, pix_in, rgb_enable,
        output rgb_pix, rgb_reading, csi_out_line, csi_out_frame, line_ovf
    );
endinterface

// File: rtl/raw2rgb_debayer_line_ram.sv
// Even-line buffer for the debayer
// Simple dual-port RAM, synchronous read, no reset so it maps to BRAM
module bayer_line_ram #(
    parameter int WIDTH = 20,
    parameter int DEPTH = 960,
    parameter int AW    = 10
) (
    input  logic             csi_clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             re,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);
    logic [WIDTH-1:0] mem [DEPTH];

    // write port and registered read port
    always_ff @(posedge csi_clk) begin
        if (we) mem[waddr] <= wdata;
        if (re) rdata <= mem[raddr];
    end
endmodule

// File: rtl/raw2rgb_debayer.sv
// RGGB RAW to 24-bit RGB, one pixel per 2x2 quad
// Buffers even lines, combines with the odd line, 2-cycle latency
module raw2rgb_debayer
    import raw2rgb_pkg::*;
#(
    parameter int PIX_W      = 10,
    parameter int LINE_PAIRS = 960,
    parameter int AW         = 10
) (
    input  logic csi_clk,
    input  logic reset,
    raw2rgb_debayer_if.slave bus
);
    localparam int RAM_AW = (LINE_PAIRS > 1) ? $clog2(LINE_PAIRS) : 1;
    localparam int BW     = 2 * PIX_W;

    logic          frame_q, line_q;
    logic          frame_rise, line_rise;
    logic          parity, first_ln;
    logic          cur_par, cur_first;
    logic [AW-1:0] wptr, rptr, wcount;
    logic [AW-1:0] cur_wptr, cur_rptr, cur_wcount;
    logic          wr_en, rd_en, ovf_set;
    logic [BW-1:0] rd_data, beat_s1;
    logic          qual_s1, par_d1;
    logic [RGB_W-1:0] rgb_pix_q;
    logic          rgb_reading_q, out_line_q, out_frame_q, ovf_q;

    // edge detection and the pointer/parity view seen by this beat
    always_comb begin
        frame_rise = bus.in_frame & ~frame_q;
        line_rise  = bus.in_line & ~line_q;
        cur_par    = parity;
        cur_first  = first_ln;
        cur_wptr   = wptr;
        cur_rptr   = rptr;
        cur_wcount = wcount;
        if (frame_rise) begin
            cur_par    = BAYER_EVEN;
            cur_first  = 1'b1;
            cur_wptr   = '0;
            cur_rptr   = '0;
            cur_wcount = '0;
        end
        if (line_rise) begin
            cur_par   = cur_first ? BAYER_EVEN : ~parity;
            cur_first = 1'b0;
            cur_wptr  = '0;
            cur_rptr  = '0;
        end
        wr_en   = bus.pix_in_valid && cur_par == BAYER_EVEN
                  && cur_wptr < AW'(LINE_PAIRS);
        ovf_set = bus.pix_in_valid && cur_par == BAYER_EVEN
                  && !(cur_wptr < AW'(LINE_PAIRS));
        rd_en   = bus.pix_in_valid && cur_par == BAYER_ODD
                  && cur_rptr < cur_wcount;
    end

    // line/frame tracking, pointers and sticky overflow
    always_ff @(posedge csi_clk) begin
        if (reset) begin
            frame_q  <= 1'b0;
            line_q   <= 1'b0;
            parity   <= BAYER_EVEN;
            first_ln <= 1'b1;
            wptr     <= '0;
            rptr     <= '0;
            wcount   <= '0;
            ovf_q    <= 1'b0;
        end else begin
            frame_q  <= bus.in_frame;
            line_q   <= bus.in_line;
            parity   <= cur_par;
            first_ln <= cur_first;
            wptr     <= wr_en ? cur_wptr + AW'(1) : cur_wptr;
            wcount   <= wr_en ? cur_wptr + AW'(1) : cur_wcount;
            rptr     <= rd_en ? cur_rptr + AW'(1) : cur_rptr;
            if (frame_rise) ovf_q <= 1'b0;
            if (ovf_set)    ovf_q <= 1'b1;
        end
    end

    bayer_line_ram #(
        .WIDTH (BW),
        .DEPTH (LINE_PAIRS),
        .AW    (RAM_AW)
    ) u_ram (
        .csi_clk (csi_clk),
        .we      (wr_en),
        .waddr   (cur_wptr[RAM_AW-1:0]),
        .wdata   (bus.pix_in),
        .re      (rd_en),
        .raddr   (cur_rptr[RAM_AW-1:0]),
        .rdata   (rd_data)
    );

    // quad combine pipeline and flag re-timing
    always_ff @(posedge csi_clk) begin
        if (reset) begin
            beat_s1       <= '0;
            qual_s1       <= 1'b0;
            par_d1        <= BAYER_EVEN;
            rgb_pix_q     <= '0;
            rgb_reading_q <= 1'b0;
            out_line_q    <= 1'b0;
            out_frame_q   <= 1'b0;
        end else begin
            if (rd_en) beat_s1 <= bus.pix_in;
            qual_s1       <= rd_en & bus.rgb_enable;
            par_d1        <= cur_par;
            rgb_reading_q <= qual_s1;
            out_line_q    <= line_q & (par_d1 == BAYER_ODD);
            out_frame_q   <= frame_q;
            if (qual_s1) begin
                rgb_pix_q <= pack_rgb(
                    8'(rd_data[PIX_W-1:0] >> (PIX_W - 8)),
                    8'(({1'b0, rd_data[BW-1:PIX_W]}
                        + {1'b0, beat_s1[PIX_W-1:0]}) >> (PIX_W - 7)),
                    8'(beat_s1[BW-1:PIX_W] >> (PIX_W - 8))
                );
            end
        end
    end

    assign bus.rgb_pix       = rgb_pix_q;
    assign bus.rgb_reading   = rgb_reading_q;
    assign bus.csi_out_line  = out_line_q;
    assign bus.csi_out_frame = out_frame_q;
    assign bus.line_ovf      = ovf_q;

endmodule

// File: tb/tb_raw2rgb_debayer.sv
// Directed bench for raw2rgb_debayer (PIX_W=10, LINE_PAIRS=4)
// Table-driven quad vectors plus multi-line frame sequences
module tb_raw2rgb_debayer;

    typedef logic [19:0] beat_t;
    typedef beat_t beat_q_t[$];

    typedef struct {
        beat_t       ev;
        beat_t       od;
        logic [23:0] exp;
    } vec_t;

    logic csi_clk = 1'b0;
    logic reset;

    int vectors = 0;
    int miscompares = 0;

    logic [23:0] got_q[$];
    logic [23:0] exp_q[$];
    int line_hi = 0;
    int align_err = 0;

    raw2rgb_debayer_if #(.PIX_W(10)) bus();

    raw2rgb_debayer #(
        .PIX_W      (10),
        .LINE_PAIRS (4),
        .AW         (10)
    ) dut (
        .csi_clk (csi_clk),
        .reset   (reset),
        .bus     (bus)
    );

    always #5 csi_clk = ~csi_clk;

    // collect output pixels and flag alignment
    always @(negedge csi_clk) begin
        if (bus.rgb_reading) got_q.push_back(bus.rgb_pix);
        if (bus.rgb_reading && !bus.csi_out_line) align_err++;
        if (bus.csi_out_line) line_hi++;
    end

    task automatic tick();
        @(posedge csi_clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [23:0] model(input beat_t ev, input beat_t od);
        int r, g, b;
        r = int'(ev[9:0]) / 4;
        g = (int'(ev[19:10]) + int'(od[9:0])) / 8;
        b = int'(od[19:10]) / 4;
        return {r[7:0], g[7:0], b[7:0]};
    endfunction

    function automatic beat_q_t mkline(input int seed, input int n);
        beat_q_t q;
        for (int i = 0; i < n; i++) begin
            int s;
            s = seed * 17 + i;
            q.push_back({10'(s * 113 + 7), 10'(s * 59 + 300)});
        end
        return q;
    endfunction

    task automatic add_exp(input beat_q_t ev, input beat_q_t od,
                           input int lim);
        for (int i = 0; i < lim && i < ev.size() && i < od.size(); i++)
            exp_q.push_back(model(ev[i], od[i]));
    endtask

    task automatic cmp_out(input string name);
        check({name, "_count"}, 32'(got_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++) begin
            logic [23:0] a;
            a = (i < got_q.size()) ? got_q[i] : 24'hxxxxxx;
            check($sformatf("%s[%0d]", name, i), 32'(a), 32'(exp_q[i]));
        end
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic run_line(input beat_q_t beats);
        bus.in_line = 1'b1;
        tick();
        foreach (beats[i]) begin
            bus.pix_in       = beats[i];
            bus.pix_in_valid = 1'b1;
            tick();
        end
        bus.pix_in_valid = 1'b0;
        bus.in_line      = 1'b0;
        repeat (3) tick();
    endtask

    task automatic frame_start();
        bus.in_frame = 1'b1;
        tick();
    endtask

    task automatic frame_end();
        bus.in_frame = 1'b0;
        repeat (2) tick();
    endtask

    initial begin
        vec_t tbl[6];
        beat_q_t a, b, c, d;

        tbl[0] = '{{10'h200, 10'h3FC}, {10'h004, 10'h100}, 24'hFF6001};
        tbl[1] = '{{10'h000, 10'h000}, {10'h000, 10'h000}, 24'h000000};
        tbl[2] = '{{10'h3FF, 10'h3FF}, {10'h3FF, 10'h3FF}, 24'hFFFFFF};
        tbl[3] = '{{10'h3FF, 10'h003}, {10'h3FB, 10'h001}, 24'h0080FE};
        tbl[4] = '{{10'h007, 10'h004}, {10'h007, 10'h000}, 24'h010001};
        tbl[5] = '{{10'h155, 10'h155}, {10'h2AA, 10'h2AA}, 24'h557FAA};

        reset            = 1'b1;
        bus.in_frame     = 1'b0;
        bus.in_line      = 1'b0;
        bus.pix_in_valid = 1'b0;
        bus.pix_in       = '0;
        bus.rgb_enable   = 1'b1;
        repeat (3) tick();
        check("rst_rgb_pix", 32'(bus.rgb_pix), 32'h0);
        check("rst_reading", 32'(bus.rgb_reading), 32'h0);
        check("rst_out_line", 32'(bus.csi_out_line), 32'h0);
        check("rst_out_frame", 32'(bus.csi_out_frame), 32'h0);
        check("rst_line_ovf", 32'(bus.line_ovf), 32'h0);
        reset = 1'b0;
        repeat (2) tick();

        // single-quad vectors with exact latency
        for (int v = 0; v < 6; v++) begin
            frame_start();
            run_line('{tbl[v].ev});
            bus.in_line = 1'b1;
            tick();
            bus.pix_in       = tbl[v].od;
            bus.pix_in_valid = 1'b1;
            tick();
            bus.pix_in_valid = 1'b0;
            check($sformatf("v%0d_lat1", v), 32'(bus.rgb_reading), 32'h0);
            tick();
            check($sformatf("v%0d_reading", v),
                  32'(bus.rgb_reading), 32'h1);
            check($sformatf("v%0d_pix", v),
                  32'(bus.rgb_pix), 32'(tbl[v].exp));
            check($sformatf("v%0d_out_line", v),
                  32'(bus.csi_out_line), 32'h1);
            tick();
            check($sformatf("v%0d_pulse", v), 32'(bus.rgb_reading), 32'h0);
            check($sformatf("v%0d_hold", v),
                  32'(bus.rgb_pix), 32'(tbl[v].exp));
            bus.in_line = 1'b0;
            repeat (3) tick();
            frame_end();
        end
        got_q.delete();

        // 4x4 frame
        line_hi   = 0;
        align_err = 0;
        a = mkline(1, 4); b = mkline(2, 4);
        c = mkline(3, 4); d = mkline(4, 4);
        frame_start();
        check("frame_out_delay", 32'(bus.csi_out_frame), 32'h0);
        tick();
        check("frame_out", 32'(bus.csi_out_frame), 32'h1);
        run_line(a); run_line(b); run_line(c); run_line(d);
        frame_end();
        add_exp(a, b, 4);
        add_exp(c, d, 4);
        cmp_out("f4x4");
        check("f4x4_line_hi", 32'(line_hi), 32'd10);
        check("f4x4_align", 32'(align_err), 32'd0);

        // overflow on a 6-beat even line
        a = mkline(10, 6); b = mkline(11, 6);
        frame_start();
        run_line(a);
        check("ovf_set", 32'(bus.line_ovf), 32'h1);
        run_line(b);
        check("ovf_sticky", 32'(bus.line_ovf), 32'h1);
        frame_end();
        check("ovf_hold", 32'(bus.line_ovf), 32'h1);
        add_exp(a, b, 4);
        cmp_out("ovf");
        frame_start();
        check("ovf_clear", 32'(bus.line_ovf), 32'h0);
        frame_end();

        // rgb_enable low for one frame
        bus.rgb_enable = 1'b0;
        a = mkline(20, 4); b = mkline(21, 4);
        frame_start();
        run_line(a); run_line(b);
        frame_end();
        cmp_out("en_off");
        bus.rgb_enable = 1'b1;
        c = mkline(22, 2); d = mkline(23, 4);
        frame_start();
        run_line(c); run_line(d);
        frame_end();
        add_exp(c, d, 2);
        cmp_out("en_on");

        // frame restart in the middle of an odd line
        a = mkline(30, 4); b = mkline(31, 4);
        frame_start();
        run_line(a);
        bus.in_line = 1'b1;
        tick();
        for (int i = 0; i < 2; i++) begin
            bus.pix_in = b[i]; bus.pix_in_valid = 1'b1; tick();
        end
        bus.pix_in_valid = 1'b0;
        bus.in_frame     = 1'b0;
        tick();
        bus.in_frame = 1'b1;
        tick();
        for (int i = 2; i < 4; i++) begin
            bus.pix_in = b[i]; bus.pix_in_valid = 1'b1; tick();
        end
        bus.pix_in_valid = 1'b0;
        bus.in_line      = 1'b0;
        repeat (3) tick();
        add_exp(a, b, 2);
        c = mkline(32, 3); d = mkline(33, 4);
        run_line(c);
        run_line(d);
        frame_end();
        add_exp(c, d, 3);
        cmp_out("restart");

        // reset during an odd line
        a = mkline(40, 4); b = mkline(41, 4);
        frame_start();
        run_line(a);
        bus.in_line = 1'b1;
        tick();
        for (int i = 0; i < 2; i++) begin
            bus.pix_in = b[i]; bus.pix_in_valid = 1'b1; tick();
        end
        bus.pix_in = b[2];
        reset      = 1'b1;
        tick();
        reset            = 1'b0;
        bus.pix_in_valid = 1'b0;
        check("mrst_rgb_pix", 32'(bus.rgb_pix), 32'h0);
        check("mrst_reading", 32'(bus.rgb_reading), 32'h0);
        check("mrst_out_line", 32'(bus.csi_out_line), 32'h0);
        check("mrst_out_frame", 32'(bus.csi_out_frame), 32'h0);
        check("mrst_line_ovf", 32'(bus.line_ovf), 32'h0);
        bus.in_line  = 1'b0;
        bus.in_frame = 1'b0;
        repeat (3) tick();
        got_q.delete();
        c = mkline(42, 4); d = mkline(43, 4);
        frame_start();
        run_line(c); run_line(d);
        frame_end();
        add_exp(c, d, 4);
        cmp_out("post_rst");

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
